// File: rtl/muldiv_seq.sv
// Iterative unsigned MULTU/DIVU sequencer owning the architectural HI/LO pair.
// Radix-2 shift-add multiply, restoring shift-subtract divide, WIDTH cycles each.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_con_Start,
    input  logic             i_con_Op,
    input  logic [WIDTH-1:0] i_data_A,
    input  logic [WIDTH-1:0] i_data_B,
    input  logic             i_con_MtHi,
    input  logic             i_con_MtLo,
    input  logic             i_con_Flush,
    output logic             o_con_Busy,
    output logic             o_con_Done,
    output logic [WIDTH-1:0] o_data_Hi,
    output logic [WIDTH-1:0] o_data_Lo
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dv_q, dv_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, done_q;

    logic [WIDTH:0]   mul_sum;
    logic [PW-1:0]    p_step;
    logic [WIDTH:0]   r_shift;
    logic             div_ge;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;
    logic             accept;

    // One iteration of each loop, evaluated every cycle from the working registers
    always_comb begin
        mul_sum = {1'b0, p_q[PW-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        p_step  = {mul_sum, p_q[WIDTH-1:1]};
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_ge  = (r_shift >= {1'b0, dv_q});
        r_step  = div_ge ? (r_shift - {1'b0, dv_q}) : r_shift;
        q_step  = {q_q[WIDTH-2:0], div_ge};
    end

    assign accept = i_con_Start && !i_con_Flush && (state_q != S_RUN);

    // Next-state and next-datapath logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        p_d     = p_q;
        m_d     = m_q;
        r_d     = r_q;
        q_d     = q_q;
        dv_d    = dv_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_RUN: begin
                if (i_con_Flush) begin
                    state_d = S_IDLE;
                end else begin
                    p_d     = p_step;
                    r_d     = r_step;
                    q_d     = q_step;
                    count_d = count_q - CW'(1);
                    if (count_q == '0) begin
                        state_d = S_DONE;
                        if (op_q) begin
                            hi_d = r_step[WIDTH-1:0];
                            lo_d = q_step;
                        end else begin
                            hi_d = p_step[PW-1:WIDTH];
                            lo_d = p_step[WIDTH-1:0];
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d = i_con_Op;
                    if (i_con_Op && (i_data_B == '0)) begin
                        // Divide by zero resolves immediately
                        state_d = S_DONE;
                        hi_d    = i_data_A;
                        lo_d    = '1;
                    end else begin
                        state_d = S_RUN;
                        p_d     = {{WIDTH{1'b0}}, i_data_A};
                        m_d     = i_data_B;
                        r_d     = '0;
                        q_d     = i_data_A;
                        dv_d    = i_data_B;
                        count_d = CW'(WIDTH - 1);
                    end
                end else begin
                    if (i_con_MtHi) hi_d = i_data_A;
                    if (i_con_MtLo) lo_d = i_data_A;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            p_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dv_q    <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            p_q     <= p_d;
            m_q     <= m_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dv_q    <= dv_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign o_con_Busy = busy_q;
    assign o_con_Done = done_q;
    assign o_data_Hi  = hi_q;
    assign o_data_Lo  = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed cases plus randomized MULTU/DIVU traffic
// checked against plain-arithmetic products, quotients and remainders.
module tb_muldiv_seq;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;
    res_t exp_q[$];
    logic [W-1:0] mdl_hi, mdl_lo;

    muldiv_seq #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_con_Start(start),
        .i_con_Op   (op),
        .i_data_A   (a),
        .i_data_B   (b),
        .i_con_MtHi (mthi),
        .i_con_MtLo (mtlo),
        .i_con_Flush(flush),
        .o_con_Busy (busy),
        .o_con_Done (done),
        .o_data_Hi  (hi),
        .o_data_Lo  (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t r;
        logic [2*W-1:0] prod;
        if (!o) begin
            prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            r.hi = prod[2*W-1:W];
            r.lo = prod[W-1:0];
        end else if (y == '0) begin
            r.hi = x;
            r.lo = '1;
        end else begin
            r.hi = x % y;
            r.lo = x / y;
        end
        return r;
    endfunction

    // Monitor: every Done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Done=1 with hi=%h lo=%h, required no Done", hi, lo);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("result_hi", 64'(hi), 64'(e.hi));
                check("result_lo", 64'(lo), 64'(e.lo));
            end
        end
    end

    // Issue one op at the current negedge; returns at the negedge where Done is seen
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic mt_with_start, input logic mt_in_run);
        res_t e;
        int cyc;
        int busy_n;
        bit div0;
        logic [W-1:0] prev_hi, prev_lo;
        div0    = o && (y == '0);
        e       = model(o, x, y);
        prev_hi = mdl_hi;
        prev_lo = mdl_lo;
        exp_q.push_back(e);
        start = 1'b1; op = o; a = x; b = y;
        mthi  = mt_with_start; mtlo = mt_with_start;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        a = $urandom; b = $urandom; op = $urandom_range(0, 1);
        cyc = 1;
        busy_n = 0;
        if (mt_with_start && !div0) begin
            check("start_beats_mt_hi", 64'(hi), 64'(prev_hi));
            check("start_beats_mt_lo", 64'(lo), 64'(prev_lo));
        end
        while (cyc < 100) begin
            if (done) break;
            if (busy) busy_n++;
            if (mt_in_run && cyc == 6) begin
                mtlo = 1'b0;
                check("mtlo_in_run_ignored", 64'(lo), 64'(prev_lo));
            end
            if (mt_in_run && cyc == 5) begin
                mtlo = 1'b1;
                a = 32'h0BAD_F00D;
            end
            @(negedge clk);
            cyc++;
        end
        mtlo = 1'b0;
        check("done_latency", 64'(cyc), div0 ? 64'd1 : 64'(W + 1));
        check("busy_cycles", 64'(busy_n), div0 ? 64'd0 : 64'(W));
        mdl_hi = e.hi;
        mdl_lo = e.lo;
    endtask

    task automatic mt(input logic h, input logic l, input logic [W-1:0] v);
        mthi = h; mtlo = l; a = v;
        @(posedge clk);
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0; a = $urandom;
        if (h) mdl_hi = v;
        if (l) mdl_lo = v;
        check("mt_hi", 64'(hi), 64'(mdl_hi));
        check("mt_lo", 64'(lo), 64'(mdl_lo));
    endtask

    // Start a MULTU that is flushed at RUN cycle flush_cyc; a stray Start is pulsed at cycle 3
    task automatic flush_op(input int flush_cyc);
        start = 1'b1; op = 1'b0; a = $urandom; b = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < flush_cyc; c++) begin
            start = (c == 3);
            op = 1'b1;
            b = '0;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_before_flush", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hi", 64'(hi), 64'(mdl_hi));
        check("flush_lo", 64'(lo), 64'(mdl_lo));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
        mdl_hi = '0; mdl_lo = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0);
        check("t1_hi", 64'(hi), 64'h0000_0000);
        check("t1_lo", 64'(lo), 64'hFFFF_FFFF);
        @(negedge clk);

        // Carry path, then back-to-back starts issued while Done is showing
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("t2_hi", 64'(hi), 64'hFFFF_FFFE);
        check("t2_lo", 64'(lo), 64'h0000_0001);
        run_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b0);
        check("t3_hi", 64'(hi), 64'd2);
        check("t3_lo", 64'(lo), 64'd14);
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_op(1'b1, 32'd5, 32'd9, 1'b0, 1'b0);
        @(negedge clk);

        run_op(1'b1, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        check("t4_hi", 64'(hi), 64'h0000_1234);
        check("t4_lo", 64'(lo), 64'hFFFF_FFFF);
        @(negedge clk);

        mt(1'b1, 1'b0, 32'hAAAA_5555);
        mt(1'b0, 1'b1, 32'h5555_AAAA);
        flush_op(10);
        flush_op(W);

        // Flush alongside Start in IDLE suppresses the accept
        start = 1'b1; flush = 1'b1; op = 1'b0; a = $urandom; b = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_blocks_start", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);

        mt(1'b1, 1'b0, 32'hDEAD_BEEF);
        mt(1'b1, 1'b1, 32'h1357_9BDF);
        run_op(1'b0, 32'd3, 32'd5, 1'b0, 1'b1);
        @(negedge clk);
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            logic o;
            logic [W-1:0] x, y;
            o = 1'($urandom_range(0, 1));
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = '0;
                1: y = W'($urandom_range(1, 300));
                default: y = $urandom;
            endcase
            run_op(o, x, y, 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a divide clears everything without a clock edge
        start = 1'b1; op = 1'b1; a = 32'hFFFF_0000; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_done", 64'(done), 64'd0);
        check("midrun_reset_hi", 64'(hi), 64'd0);
        check("midrun_reset_lo", 64'(lo), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        mdl_hi = '0; mdl_lo = '0;
        repeat (3) @(negedge clk);
        check("post_reset_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
